// File: rtl/voice_mix_pkg.sv
// +----------------------------------------------------------------------------+
// | voice_mix_pkg: shared types, gain constant and default widths for the mixer.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package voice_mix_pkg;

  typedef enum logic [1:0] {
    MIX_IDLE  = 2'd0,
    MIX_ACCUM = 2'd1,
    MIX_FLUSH = 2'd2
  } mix_state_t;

  localparam logic [15:0] GAIN_UNITY = 16'h8000;

  localparam int NUMVOICES_DEF   = 10;
  localparam int VOICE_AW_DEF    = 4;
  localparam int DW_DEF          = 32;
  localparam int HEADROOM_SH_DEF = 4;
  localparam int OUT_W_DEF       = 32;

endpackage

`default_nettype wire

// File: rtl/voice_out_fifo.sv
// +----------------------------------------------------------------------------+
// | voice_out_fifo: 2-deep show-ahead FIFO; a pop frees room for a same-cycle   |
// | push when full. Rev 1.0                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module voice_out_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full,
  output logic         drop
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count == 2'd0);
  assign full    = count[1];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

`default_nettype wire

// File: rtl/voice_mix_accum.sv
// +----------------------------------------------------------------------------+
// | voice_mix_accum: per-voice gain, frame sum, scale/limit, buffer for I2S.    |
// | Optional VOICE_MIX_SAT_EN clamps instead of wrapping. Rev 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

module voice_mix_accum
  import voice_mix_pkg::*;
#(
  parameter int NUMVOICES   = NUMVOICES_DEF,
  parameter int VOICE_AW    = VOICE_AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int ACC_W       = DW + VOICE_AW + 3,
  parameter int HEADROOM_SH = HEADROOM_SH_DEF,
  parameter int OUT_W       = OUT_W_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 in_valid,
  input  logic [VOICE_AW-1:0]  in_idx,
  input  logic signed [DW-1:0] in_sample,
  input  logic                 gain_wr,
  input  logic [VOICE_AW-1:0]  gain_idx,
  input  logic [15:0]          gain_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  input  logic                 status_clr,
  output logic                 overrun,
  output logic                 frame_err
);

  localparam logic [VOICE_AW-1:0] LAST_IDX = VOICE_AW'(NUMVOICES - 1);
  localparam logic [VOICE_AW:0]   NV       = (VOICE_AW + 1)'(NUMVOICES);

  logic [15:0]             gain [NUMVOICES];
  logic [15:0]             gain_rd;
  logic [VOICE_AW-1:0]     exp_idx;
  mix_state_t              state, state_nxt;

  logic                    match, restart, take, bad, is_last;
  logic signed [DW+16:0]   samp_ext, gain_ext, prod_full;
  logic signed [ACC_W-1:0] prod_ext;

  logic                    p_valid, p_first, p_last;
  logic signed [ACC_W-1:0] p_val;
  logic signed [ACC_W-1:0] acc;
  logic                    acc_done;
  logic signed [ACC_W-1:0] sh;
  logic [OUT_W-1:0]        limited;

  logic                    fifo_empty, fifo_drop, unused_full;

  assign match   = in_valid && (in_idx == exp_idx);
  assign restart = in_valid && (in_idx != exp_idx) && (in_idx == '0);
  assign take    = match || restart;
  assign bad     = in_valid && !match;
  assign is_last = (in_idx == LAST_IDX);

  // Reads see the pre-write value, so a same-cycle write applies from the next sample.
  assign gain_rd   = ({1'b0, in_idx} < NV) ? gain[in_idx] : GAIN_UNITY;
  assign samp_ext  = (DW + 17)'(in_sample);
  assign gain_ext  = (DW + 17)'($signed({1'b0, gain_rd}));
  assign prod_full = samp_ext * gain_ext;
  assign prod_ext  = ACC_W'(prod_full >>> 15);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUMVOICES; i++) gain[i] <= GAIN_UNITY;
    end else if (gain_wr && ({1'b0, gain_idx} < NV)) begin
      gain[gain_idx] <= gain_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      exp_idx  <= '0;
      p_valid  <= 1'b0;
      p_first  <= 1'b0;
      p_last   <= 1'b0;
      p_val    <= '0;
      acc      <= '0;
      acc_done <= 1'b0;
    end else begin
      if (take) begin
        exp_idx <= is_last ? '0 : in_idx + 1'b1;
      end else if (bad) begin
        exp_idx <= '0;
      end
      p_valid <= take;
      p_first <= (in_idx == '0);
      p_last  <= take && is_last;
      if (take) p_val <= prod_ext;
      if (p_valid) acc <= p_first ? p_val : acc + p_val;
      acc_done <= p_valid && p_last;
    end
  end

  assign sh = acc >>> HEADROOM_SH;

`ifdef VOICE_MIX_SAT_EN
  always_comb begin
    limited = sh[OUT_W-1:0];
    if (sh[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){sh[ACC_W-1]}}) begin
      limited = sh[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic unused_hi;
  assign limited   = sh[OUT_W-1:0];
  assign unused_hi = ^sh[ACC_W-1:OUT_W];
`endif

  voice_out_fifo #(.W(OUT_W)) u_fifo (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (acc_done),
    .push_data (limited),
    .pop       (out_ready),
    .head      (out_data),
    .empty     (fifo_empty),
    .full      (unused_full),
    .drop      (fifo_drop)
  );

  assign out_valid = !fifo_empty;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (fifo_drop)       overrun <= 1'b1;
      else if (status_clr) overrun <= 1'b0;
      if (bad)             frame_err <= 1'b1;
      else if (status_clr) frame_err <= 1'b0;
    end
  end

  // Tracks input framing; the datapath push trails FLUSH by the pipeline depth.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= MIX_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MIX_IDLE: begin
        if (take) state_nxt = is_last ? MIX_FLUSH : MIX_ACCUM;
      end
      MIX_ACCUM, MIX_FLUSH: begin
        if (take)         state_nxt = is_last ? MIX_FLUSH : MIX_ACCUM;
        else if (bad)     state_nxt = MIX_IDLE;
        else if (state == MIX_FLUSH) state_nxt = MIX_IDLE;
      end
      default: state_nxt = MIX_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_voice_mix_accum.sv
// Scoreboard bench for voice_mix_accum: directed frames, expected words queued,
// monitor pops and compares on every output transfer.
`default_nettype none

module tb_voice_mix_accum;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_idx = '0;
  logic [31:0] in_sample = '0;
  logic        gain_wr = 1'b0;
  logic [3:0]  gain_idx = '0;
  logic [15:0] gain_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        status_clr = 1'b0;
  logic        overrun;
  logic        frame_err;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 Clk = ~Clk;

  voice_mix_accum dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .in_valid   (in_valid),
    .in_idx     (in_idx),
    .in_sample  (in_sample),
    .gain_wr    (gain_wr),
    .gain_idx   (gain_idx),
    .gain_data  (gain_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .status_clr (status_clr),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_voice(input int idx, input logic [31:0] s);
    in_valid  = 1'b1;
    in_idx    = 4'(idx);
    in_sample = s;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] s);
    for (int i = 0; i < 10; i++) send_voice(i, s);
  endtask

  task automatic write_gain(input int idx, input logic [15:0] g);
    gain_wr   = 1'b1;
    gain_idx  = 4'(idx);
    gain_data = g;
    tick();
    gain_wr   = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    repeat (4) tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted output word must match the oldest expectation.
  initial begin
    forever begin
      @(negedge Clk);
      if (Reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_data, 32'hDEAD_BEEF ^ out_data ^ 32'h1);
        end else begin
          check("word", out_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  out_data,       32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    tick();

    // Unity sum with latency check
    exp_q.push_back(32'h00A0_0000);
    send_frame(32'h0100_0000);
    @(negedge Clk); check("lat_c1", 32'(out_valid), 32'd0);
    @(negedge Clk); check("lat_c2", 32'(out_valid), 32'd0);
    @(negedge Clk); check("lat_c3", 32'(out_valid), 32'd1);
    #1;
    drain("drain_unity");

    // Back-to-back frames
    exp_q.push_back(32'h00A0_0000);
    exp_q.push_back(32'h0140_0000);
    send_frame(32'h0100_0000);
    send_frame(32'h0200_0000);
    drain("drain_b2b");

    // Gains: voice 3 muted, voice 5 halved
    write_gain(3, 16'h0000);
    write_gain(5, 16'h4000);
    write_gain(12, 16'h0000);
    exp_q.push_back(32'h0088_0000);
    send_frame(32'h0100_0000);
    drain("drain_gain");

    // Backpressure: three frames into a 2-deep buffer
    out_ready = 1'b0;
    exp_q.push_back(32'h0088_0000);
    exp_q.push_back(32'h0110_0000);
    send_frame(32'h0100_0000);
    send_frame(32'h0200_0000);
    send_frame(32'h0300_0000);
    repeat (5) tick();
    check("bp_overrun",   32'(overrun),   32'd1);
    check("bp_frame_err", 32'(frame_err), 32'd0);
    check("bp_head",      out_data,       32'h0088_0000);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    drain("drain_bp");

    // Order error, then a clean frame
    send_voice(0, 32'h0100_0000);
    send_voice(1, 32'h0100_0000);
    send_voice(2, 32'h0100_0000);
    send_voice(7, 32'h0100_0000);
    repeat (6) tick();
    check("err_frame_err", 32'(frame_err), 32'd1);
    check("err_no_output", 32'(out_valid), 32'd0);
    exp_q.push_back(32'h0008_8000);
    send_frame(32'h0010_0000);
    drain("drain_clean");

    // Mid-frame reset
    for (int i = 0; i < 5; i++) send_voice(i, 32'h0100_0000);
    Reset_n = 1'b0;
    #2;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_out_data",  out_data,       32'd0);
    check("mrst_overrun",   32'(overrun),   32'd0);
    check("mrst_frame_err", 32'(frame_err), 32'd0);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    exp_q.push_back(32'h00A0_0000);
    send_frame(32'h0100_0000);
    drain("drain_post_reset");
    check("post_reset_frame_err", 32'(frame_err), 32'd0);

    // Saturation / wrap
    for (int i = 0; i < 10; i++) write_gain(i, 16'hFFFF);
`ifdef VOICE_MIX_SAT_EN
    exp_q.push_back(32'h7FFF_FFFF);
`else
    exp_q.push_back(32'h9FFF_5FFE);
`endif
    send_frame(32'h7FFF_FFFF);
    drain("drain_sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
